mipi_lane_state_monitor: RTL
============================

# mipi_lane_state_monitor

Per-lane MIPI D-PHY low-power state monitor that tracks the LP11→LP01→LP00 start-of-transmission sequence on up to four data lanes and qualifies the HS burst window for the downstream HS byte aligner / packet parser. It extends the single-lane detector with the following:
- parametrised lane count;
- input synchronisers;
- a programmable HS-settle delay;
- burst exit on either the Crosslink contention-detector (CD) output or a return to LP11;
- a burst timeout;
- SoT/EoT/error pulses;
- a completed-burst counter.

## Interface
Parameters:
- NUM_LANES, 4, number of data lanes monitored (1–4).
- SETTLE_CYC, 4, sys_clk cycles spent in HS_PRPR before the burst is declared (≥1).
- TIMEOUT_CYC, 65535, maximum burst length in sys_clk cycles before forced exit (≥2, counter 16 bits).

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- lane_en  in  NUM_LANES  per-lane enable; 0 forces that lane to STOP.
- lp_lane  in  2*NUM_LANES  LP pair per lane, lane i = bits [2i+1:2i] = {Dp,Dn}, asynchronous.
- lp_lane_cd  in  NUM_LANES  CD output per lane, asynchronous, 1 = LP level detected.
- hs_burst_flag  out  NUM_LANES  1 while the lane is in HS_BURST.
- hs_burst_all  out  1  AND of hs_burst_flag over enabled lanes; 0 if no lane is enabled.
- sot_pulse  out  NUM_LANES  1-cycle pulse on HS_PRPR→HS_BURST.
- eot_pulse  out  NUM_LANES  1-cycle pulse on normal burst exit (CD or LP11).
- err_pulse  out  NUM_LANES  1-cycle pulse on a protocol error or timeout.
- burst_count  out  16  completed bursts on lane 0 (normal exits only), wraps 0xFFFF→0.

## Operation
- Each lp_lane and lp_lane_cd bit passes through its own 2-flop synchroniser.
  - Synchroniser reset values: lp = LP11, cd = 0.
  - The FSM acts only on the synchronised values (lp_s, cd_s).
- There is one independent FSM per lane. States: STOP, HS_RQST, HS_PRPR, HS_BURST, WAIT_STOP.
  - STOP: lp_s = LP01 → HS_RQST; lp_s = LP10 (escape/turnaround, not decoded) → WAIT_STOP; otherwise stay.
  - HS_RQST: LP00 → HS_PRPR and clear the settle counter; LP11 → STOP (no error); LP10 → WAIT_STOP with err_pulse; LP01 → stay.
  - HS_PRPR: the settle counter increments each cycle; LP11 → STOP with err_pulse (aborted SoT). When the counter equals SETTLE_CYC-1 → HS_BURST with sot_pulse and the timeout counter cleared.
  - HS_BURST: hs_burst_flag = 1.
    - cd_s = 1 or lp_s = LP11 → STOP with eot_pulse.
    - Otherwise, when the timeout counter equals TIMEOUT_CYC-1 → WAIT_STOP with err_pulse.
    - If exit and timeout occur in the same cycle, the exit wins: eot_pulse only.
  - WAIT_STOP: lp_s = LP11 → STOP; otherwise stay.
- lane_en[i] = 0 sends lane i to STOP on the next edge from any state and clears its counters. It generates no pulses, and dropping lane_en mid-burst produces no eot_pulse.
- burst_count increments on every lane-0 eot_pulse. It does not count timeouts.
- The FSM ignores lp_s inside HS_BURST except for LP11; HS line levels on the LP receivers read as LP00.

## Timing
- Reset values: all FSMs in STOP; hs_burst_flag = 0, hs_burst_all = 0, sot/eot/err_pulse = 0, burst_count = 0; all counters 0.
- All outputs are registered, and the flags and pulses change on the edge of the state transition.
- Input latency: a pin level that is stable from before edge p is acted on at edge p+2.
- SoT latency: LP00 presented before edge p → HS_PRPR at edge p+2 → HS_BURST, hs_burst_flag = 1 and sot_pulse after edge p+2+SETTLE_CYC.
- EoT latency: CD or LP11 presented before edge q → hs_burst_flag = 0 and eot_pulse after edge q+2.
- Timeout: hs_burst_flag stays high for exactly TIMEOUT_CYC cycles, then drops with err_pulse.
- hs_burst_all is combinational from registered flags and lane_en, so it has zero additional latency.
- Reset asserted mid-burst: all outputs return to their reset values immediately (asynchronous), with no pulse.

## Test plan
- Lane 0: LP11→LP01 (5 cycles)→LP00 (10 cycles)→CD = 1, with SETTLE_CYC = 4 → flag rises 6 cycles after LP00 reaches the pin and falls 2 cycles after CD; one sot_pulse, one eot_pulse; burst_count = 1.
- 4 lanes with lane_en = 4'b1011 and a simultaneous SoT on lanes 0, 1 and 3, while lane 2 idles at LP11 → hs_burst_all = 1 for the burst duration; lane 2 flag stays 0.
- LP01→LP00 then LP11 after 2 cycles (SETTLE_CYC = 4) → no flag, err_pulse = 1 on that lane; FSM back in STOP; a subsequent valid SoT succeeds.
- TIMEOUT_CYC = 16, LP00 held with no CD → flag high for exactly 16 cycles, then err_pulse; lane stays in WAIT_STOP until LP11; burst_count unchanged.
- Lane 0: LP11→LP10→LP00→LP01→LP11 → WAIT_STOP, no sot_pulse, no err_pulse; back to STOP after LP11.
- sys_rst_n pulsed low mid-burst, and separately lane_en[0] dropped mid-burst → flag cleared with no eot_pulse; burst_count is 0 after the reset and unchanged after the lane_en drop.

Source files
------------

// File: rtl/mipi_lane_state_monitor.sv
// Per-lane MIPI D-PHY LP state monitor: tracks the LP11->LP01->LP00 start-of-transmission
// sequence on each lane and qualifies the HS burst window with SoT/EoT/error pulses.
module mipi_lane_state_monitor #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [NUM_LANES-1:0]   lane_en,
  input  logic [2*NUM_LANES-1:0] lp_lane,
  input  logic [NUM_LANES-1:0]   lp_lane_cd,
  output logic [NUM_LANES-1:0]   hs_burst_flag,
  output logic                   hs_burst_all,
  output logic [NUM_LANES-1:0]   sot_pulse,
  output logic [NUM_LANES-1:0]   eot_pulse,
  output logic [NUM_LANES-1:0]   err_pulse,
  output logic [15:0]            burst_count
);

  localparam logic [1:0] LP00 = 2'b00;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP11 = 2'b11;

  typedef enum logic [2:0] {StStop, StHsRqst, StHsPrpr, StHsBurst, StWaitStop} state_e;

  logic [2*NUM_LANES-1:0] lp_meta_q, lp_s_q;
  logic [NUM_LANES-1:0]   cd_meta_q, cd_s_q;
  logic [NUM_LANES-1:0]   eot_take;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lp_meta_q <= '1;
      lp_s_q    <= '1;
      cd_meta_q <= '0;
      cd_s_q    <= '0;
    end else begin
      lp_meta_q <= lp_lane;
      lp_s_q    <= lp_meta_q;
      cd_meta_q <= lp_lane_cd;
      cd_s_q    <= cd_meta_q;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    state_e      state_q;
    logic [15:0] settle_q;
    logic [15:0] tout_q;
    logic        flag_q, sot_q, eot_q, err_q;
    logic [1:0]  lp;

    assign lp = lp_s_q[2*i+:2];
    // Normal exit has priority over the timeout, so it is decoded once here and reused.
    assign eot_take[i] = lane_en[i] && (state_q == StHsBurst) && (cd_s_q[i] || lp == LP11);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state_q  <= StStop;
        settle_q <= '0;
        tout_q   <= '0;
        flag_q   <= 1'b0;
        sot_q    <= 1'b0;
        eot_q    <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        sot_q <= 1'b0;
        eot_q <= 1'b0;
        err_q <= 1'b0;
        if (!lane_en[i]) begin
          state_q  <= StStop;
          settle_q <= '0;
          tout_q   <= '0;
          flag_q   <= 1'b0;
        end else begin
          case (state_q)
            StStop: begin
              if (lp == LP01) state_q <= StHsRqst;
              else if (lp == LP10) state_q <= StWaitStop;
            end
            StHsRqst: begin
              unique case (lp)
                LP00: begin
                  state_q  <= StHsPrpr;
                  settle_q <= '0;
                end
                LP11: state_q <= StStop;
                LP10: begin
                  state_q <= StWaitStop;
                  err_q   <= 1'b1;
                end
                default: state_q <= StHsRqst;
              endcase
            end
            StHsPrpr: begin
              if (lp == LP11) begin
                state_q <= StStop;
                err_q   <= 1'b1;
              end else if (settle_q == 16'(SETTLE_CYC - 1)) begin
                state_q <= StHsBurst;
                flag_q  <= 1'b1;
                sot_q   <= 1'b1;
                tout_q  <= '0;
              end else begin
                settle_q <= settle_q + 16'd1;
              end
            end
            StHsBurst: begin
              if (eot_take[i]) begin
                state_q <= StStop;
                flag_q  <= 1'b0;
                eot_q   <= 1'b1;
              end else if (tout_q == 16'(TIMEOUT_CYC - 1)) begin
                state_q <= StWaitStop;
                flag_q  <= 1'b0;
                err_q   <= 1'b1;
              end else begin
                tout_q <= tout_q + 16'd1;
              end
            end
            StWaitStop: begin
              if (lp == LP11) state_q <= StStop;
            end
            default: begin
              state_q <= StStop;
              flag_q  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign hs_burst_flag[i] = flag_q;
    assign sot_pulse[i]     = sot_q;
    assign eot_pulse[i]     = eot_q;
    assign err_pulse[i]     = err_q;
  end

  assign hs_burst_all = (|lane_en) & (&(hs_burst_flag | ~lane_en));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      burst_count <= '0;
    end else if (eot_take[0]) begin
      burst_count <= burst_count + 16'd1;
    end
  end

endmodule
